// File: rtl/delay_line.sv
`default_nettype none
// ============================================================================
// Module   : delay_line
// Purpose  : Programmable-depth tagged delay line. Each sample carries a valid
//            tag. It emerges dly ce-cycles after entry, where dly is clamped to
//            the range 1..DEPTH. Changing the delay or asserting flush drops
//            every in-flight tag. Data values are never altered by these
//            events, so stale data can reach out_data but is never marked
//            valid.
// Ports    : ck        - clock, rising edge
//            rst       - synchronous active-high reset
//            ce        - clock enable, advances the line one stage
//            flush     - clears every valid tag, including the entering one
//            dly       - requested delay in ce-cycles (DW bits)
//            in_valid  - input sample tag
//            in_data   - input sample (WIDTH bits)
//            out_valid - tag of the delayed sample
//            out_data  - delayed sample (WIDTH bits)
//            fill      - ce-cycles since the last clear, saturating at dly_q
//                        (only when DELAY_LINE_FILL_EN is defined)
//            primed    - registered (fill == dly_q)
//                        (only when DELAY_LINE_FILL_EN is defined)
// Options  : DELAY_LINE_FILL_EN - adds the fill / primed outputs
// Revision : 1.0 - initial release
// ============================================================================
module delay_line #(
  parameter int               WIDTH = 8,
  parameter int               DEPTH = 16,
  parameter logic [WIDTH-1:0] INIT  = '0,
  localparam int              DW    = $clog2(DEPTH + 1)
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             ce,
  input  logic             flush,
  input  logic [DW-1:0]    dly,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
`ifdef DELAY_LINE_FILL_EN
  ,
  output logic [DW-1:0]    fill,
  output logic             primed
`endif
);

  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DW-1:0]               dly_q, dly_d;
  logic [DW-1:0]               dly_clamp;
  logic                        dly_chg;

  // Clamp the requested delay into 1..DEPTH.
  always_comb begin
    dly_clamp = dly;
    if (dly == '0) begin
      dly_clamp = DW'(1);
    end else if (dly > DW'(DEPTH)) begin
      dly_clamp = DW'(DEPTH);
    end
  end

  assign dly_chg = (dly_clamp != dly_q);

  // Next state of the stage array. Reset overrides everything. Flush and a
  // delay change only touch the tags, so a shift still moves the data.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    dly_d   = dly_clamp;
    if (ce) begin
      for (int i = DEPTH - 1; i >= 1; i--) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      data_d[0]  = in_data;
      valid_d[0] = in_valid;
    end
    if (flush || dly_chg) begin
      valid_d = '0;
    end
    if (rst) begin
      data_d  = {DEPTH{INIT}};
      valid_d = '0;
    end
  end

  always_ff @(posedge ck) begin
    data_q  <= data_d;
    valid_q <= valid_d;
    dly_q   <= dly_d;
  end

  // The output tap is selected by dly_q only, so out_* depend on registers
  // alone and have no path from any input.
  always_comb begin
    out_data  = data_q[0];
    out_valid = valid_q[0];
    for (int i = 0; i < DEPTH; i++) begin
      if (dly_q == DW'(i + 1)) begin
        out_data  = data_q[i];
        out_valid = valid_q[i];
      end
    end
  end

`ifdef DELAY_LINE_FILL_EN
  logic [DW-1:0] fill_q, fill_d;
  logic          primed_q;

  // fill counts ce edges since the last tag clear. Once it reaches dly_q, the
  // sample at the output tap entered after that clear.
  always_comb begin
    fill_d = fill_q;
    if (rst || flush || dly_chg) begin
      fill_d = '0;
    end else if (ce && (fill_q < dly_q)) begin
      fill_d = fill_q + DW'(1);
    end
  end

  always_ff @(posedge ck) begin
    fill_q <= fill_d;
    if (rst) begin
      primed_q <= 1'b0;
    end else begin
      primed_q <= (fill_d == dly_d);
    end
  end

  assign fill   = fill_q;
  assign primed = primed_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_line
// Purpose  : Directed self-checking bench for delay_line. It uses WIDTH=8,
//            DEPTH=16 and INIT=0xA5.
// Options  : DELAY_LINE_FILL_EN - also exercises the fill / primed outputs
// Revision : 1.0 - initial release
// ============================================================================
module tb_delay_line;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int DW    = $clog2(DEPTH + 1);
  localparam logic [WIDTH-1:0] INIT = 8'hA5;

  logic             ck = 1'b0;
  logic             rst = 1'b1;
  logic             ce = 1'b0;
  logic             flush = 1'b0;
  logic [DW-1:0]    dly = 5'd4;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
`ifdef DELAY_LINE_FILL_EN
  logic [DW-1:0]    fill;
  logic             primed;
`endif

  int n_cmp = 0;
  int n_err = 0;

  delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .INIT  (INIT)
  ) dut (
    .ck        (ck),
    .rst       (rst),
    .ce        (ce),
    .flush     (flush),
    .dly       (dly),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data)
`ifdef DELAY_LINE_FILL_EN
    ,
    .fill      (fill),
    .primed    (primed)
`endif
  );

  always #5 ck = ~ck;

  // One clock edge, then settle before sampling.
  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reset while ce, flush and in_* are all active. Reset must win, and dly_q
  // must load with the clamped delay so that no change is seen afterwards.
  task automatic do_reset(input logic [DW-1:0] d);
    rst = 1'b1; ce = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 8'hFF; dly = d;
    step();
    rst = 1'b0; ce = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation ran past time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] exp;

    // Reset state
    do_reset(5'd4);
    chk("reset", {out_valid, out_data}, {1'b0, 8'hA5});

    // Basic latency, dly=4
    ce = 1'b1; in_valid = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      in_data = 8'(j);
      step();
      exp = (j >= 4) ? {1'b1, 8'(j - 3)} : {1'b0, 8'hA5};
      chk("latency4", {out_valid, out_data}, exp);
    end

    // Stall, dly=3, ce alternating
    do_reset(5'd3);
    for (int c = 1; c <= 6; c++) begin
      ce = 1'b1; in_valid = 1'b1; in_data = 8'(8'h30 + c);
      step();
      exp = (c >= 3) ? {1'b1, 8'(8'h30 + c - 2)} : {1'b0, 8'hA5};
      chk("stall_ce1", {out_valid, out_data}, exp);
      ce = 1'b0; in_data = 8'hEE;
      step();
      chk("stall_hold", {out_valid, out_data}, exp);
    end

    // Clamp low, dly=0 -> latency 1
    do_reset(5'd0);
    ce = 1'b1; in_valid = 1'b1; in_data = 8'h40;
    step();
    chk("clamp0_a", {out_valid, out_data}, {1'b1, 8'h40});
    in_data = 8'h41;
    step();
    chk("clamp0_b", {out_valid, out_data}, {1'b1, 8'h41});

    // Clamp high, dly=20 -> latency 16
    do_reset(5'd20);
    ce = 1'b1; in_valid = 1'b1;
    for (int j = 1; j <= 17; j++) begin
      in_data = 8'(8'h50 + j);
      step();
      exp = (j >= 16) ? {1'b1, 8'(8'h50 + j - 15)} : {1'b0, 8'hA5};
      chk("clamp20", {out_valid, out_data}, exp);
    end

    // Delay change 4 -> 2
    do_reset(5'd4);
    ce = 1'b1; in_valid = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      in_data = 8'(8'h60 + j);
      step();
    end
    chk("chg_before", {out_valid, out_data}, {1'b1, 8'h65});
    dly = 5'd2; in_data = 8'h69;
    step();
    chk("chg_e0", {out_valid, out_data}, {1'b0, 8'h68});
    in_data = 8'h6A;
    step();
    chk("chg_e1", {out_valid, out_data}, {1'b0, 8'h69});
    in_data = 8'h6B;
    step();
    chk("chg_e2", {out_valid, out_data}, {1'b1, 8'h6A});
    in_data = 8'h6C;
    step();
    chk("chg_e3", {out_valid, out_data}, {1'b1, 8'h6B});

    // Flush with ce=1, then reset mid-stream
    do_reset(5'd4);
    ce = 1'b1; in_valid = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      in_data = 8'(8'h70 + j);
      step();
    end
    chk("fl_before", {out_valid, out_data}, {1'b1, 8'h73});
    flush = 1'b1; in_data = 8'h77;
    step();
    chk("fl_e0", {out_valid, out_data}, {1'b0, 8'h74});
    flush = 1'b0; in_data = 8'h78;
    step();
    chk("fl_e1", {out_valid, out_data}, {1'b0, 8'h75});
    in_data = 8'h79;
    step();
    chk("fl_e2", {out_valid, out_data}, {1'b0, 8'h76});
    in_data = 8'h7A;
    step();
    chk("fl_e3", {out_valid, out_data}, {1'b0, 8'h77});
    in_data = 8'h7B;
    step();
    chk("fl_e4", {out_valid, out_data}, {1'b1, 8'h78});
    rst = 1'b1; in_data = 8'h7C;
    step();
    chk("rst_mid", {out_valid, out_data}, {1'b0, 8'hA5});
    rst = 1'b0; in_data = 8'h7D;
    step();
    chk("rst_after", {out_valid, out_data}, {1'b0, 8'hA5});
    ce = 1'b0; in_valid = 1'b0;

`ifdef DELAY_LINE_FILL_EN
    // Fill / primed, dly=5
    do_reset(5'd5);
    chk("fill_rst", {6'(fill), primed}, {5'd0, 1'b0});
    ce = 1'b1; in_valid = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      in_data = 8'(8'h80 + j);
      step();
      chk("fill_cnt", 16'(fill), (j < 5) ? 16'(j) : 16'd5);
      chk("fill_primed", 16'(primed), (j >= 5) ? 16'd1 : 16'd0);
      chk("fill_valid", 16'(out_valid), (j >= 5) ? 16'd1 : 16'd0);
    end
    ce = 1'b0;
    step();
    chk("fill_hold", {6'(fill), primed}, {5'd5, 1'b1});
    ce = 1'b1; flush = 1'b1;
    step();
    chk("fill_flush", {6'(fill), primed, out_valid}, {5'd0, 1'b0, 1'b0});
    flush = 1'b0; ce = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/delay_line.md
DELAY_LINE -- requirements
Module: delay_line

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per sample.
REQ-002 SHALL have parameter DEPTH, default 16: maximum delay in stages; DEPTH >= 1.
REQ-003 SHALL have parameter INIT, default 0: reset value of every data stage.
REQ-004 SHALL use localparam DW = $clog2(DEPTH+1): width of dly and fill.
REQ-005 SHALL have port ck, input, 1: clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port ce, input, 1: clock enable; advances the line one stage.
REQ-008 SHALL have port flush, input, 1: clears all valid tags.
REQ-009 SHALL have port dly, input, DW: requested delay in ce-cycles.
REQ-010 SHALL have port in_valid, input, 1: input sample tag.
REQ-011 SHALL have port in_data, input, WIDTH: input sample.
REQ-012 SHALL have port out_valid, output, 1: tag of the delayed sample.
REQ-013 SHALL have port out_data, output, WIDTH: delayed sample.

Function
REQ-014 SHALL hold DEPTH registered stages of {valid, data}; stage 0 is nearest the input.
REQ-015 SHALL clamp dly to the range 1..DEPTH (0 -> 1, >DEPTH -> DEPTH) and register the result as dly_q every cycle.
REQ-016 SHALL drive out_data = data[dly_q-1] and out_valid = valid[dly_q-1] from registers, with no combinational path from any input.
REQ-017 SHALL, on a cycle with ce=1, shift every stage up by one and load stage 0 with {in_valid, in_data}; stage DEPTH-1 is discarded.
REQ-018 SHALL, on a cycle with ce=0, hold all stages; out_* stay constant unless a dly change occurs (REQ-020).
REQ-019 SHALL, with ce held high and dly_q constant, present a sample taken at edge n on out_* after edge n+dly_q-1, i.e. latency = dly_q ce-cycles.
REQ-020 SHALL, when the clamped dly differs from dly_q, update dly_q and clear all valid bits on the same edge; data still shifts if ce=1. Stale data is never tagged valid.
REQ-021 SHALL, on flush=1, clear all valid bits including the sample entering on that edge; data still shifts if ce=1.
REQ-022 SHALL give priority rst > flush = dly change > ce shift.
REQ-023 SHALL never alter data values on flush or dly change; only the valid tags are cleared.

Reset
REQ-024 SHALL, on rst=1 at an edge, clear all valid bits, set all data stages to INIT, and set dly_q to clamp(dly).
REQ-025 SHALL drive out_valid=0 and out_data=INIT in the cycle after reset.
REQ-026 SHALL ignore ce, flush and in_* while rst=1; reset mid-stream discards all in-flight samples.

Configuration
REQ-027 SHALL, when macro DELAY_LINE_FILL_EN is defined, add output fill (DW bits) and output primed (1 bit).
REQ-028 SHALL, under DELAY_LINE_FILL_EN, set fill to 0 on rst, flush or dly change; otherwise fill increments on ce=1 and saturates at dly_q.
REQ-029 SHALL, under DELAY_LINE_FILL_EN, drive primed = (fill == dly_q), registered; primed is 0 after reset.
REQ-030 SHALL, without DELAY_LINE_FILL_EN, omit the fill/primed ports and logic; all other behaviour is identical.

Verification
REQ-031 SHALL check basic latency: WIDTH=8, DEPTH=16, dly=4, ce=1, in_data=0x01,0x02,... with in_valid=1 -> out_data=0x01 with out_valid=1 four edges after first input, then one new value per cycle.
REQ-032 SHALL check stall: dly=3, ce toggled 1,0,1,0... -> each sample appears after exactly 3 ce=1 edges, and out_* hold during ce=0.
REQ-033 SHALL check clamping: dly=0 -> latency 1; dly=20 with DEPTH=16 -> latency 16.
REQ-034 SHALL check a dly change: running at dly=4, switch to dly=2 -> out_valid=0 until 2 ce edges after the switch, then new samples only, no stale samples.
REQ-035 SHALL check flush and reset: flush=1 with ce=1 -> that input and all in-flight samples never emerge valid. rst mid-stream -> out_valid=0 and out_data=INIT (INIT=0xA5) next cycle.
REQ-036 SHALL check the fill feature: with DELAY_LINE_FILL_EN, dly=5 -> fill counts 0..5 over ce edges, primed=1 coincident with the first valid output, and both return to 0 on flush.
